// File: rtl/ps2_scan_filter.sv
// PS/2 set-2 scan-code filter: turns the raw byte stream into one key event per key action.
// Optional typematic repeat suppression is enabled by defining SCAN_FILTER_REPEAT_SUPPRESS_EN.
module ps2_scan_filter #(
  parameter int TIMEOUT_CYCLES = 100_000,
  parameter bit REPORT_BREAKS  = 1'b1,
  parameter int PAUSE_LEN      = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ready,
  input  logic [7:0] data_in,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       proto_err
);

  localparam int CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SKIP_W = (PAUSE_LEN > 1) ? $clog2(PAUSE_LEN + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SKIP_W-1:0] SKIP_LEN = SKIP_W'(PAUSE_LEN);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_E0    = 3'd1,
    ST_F0    = 3'd2,
    ST_E0F0  = 3'd3,
    ST_PAUSE = 3'd4
  } state_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == 8'hE0) || (b == 8'hE1) || (b == 8'hF0);
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == 8'h12) || (b == 8'h59);
  endfunction

  function automatic logic is_reply(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFC) || (b == 8'hFD);
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              ready_q;
  logic              key_valid_q, proto_err_q, key_ext_q, key_break_q;
  logic [7:0]        key_code_q;

  logic accept_s, emit_s, emit_ext_s, emit_brk_s, err_s, suppress_s, fire_s;

  assign accept_s = ready & ~ready_q;

  // Byte decode and prefix timeout; an accepted byte always takes priority over expiry.
  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    cnt_d      = cnt_q;
    emit_s     = 1'b0;
    emit_ext_s = 1'b0;
    emit_brk_s = 1'b0;
    err_s      = 1'b0;
    if (accept_s) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (data_in == 8'hE0) begin
            state_d = ST_E0;
          end else if (data_in == 8'hF0) begin
            state_d = ST_F0;
          end else if (data_in == 8'hE1) begin
            state_d = ST_PAUSE;
            skip_d  = SKIP_LEN;
          end else if (is_reply(data_in)) begin
            state_d = ST_IDLE;
          end else if ((data_in == 8'h00) || (data_in == 8'hFF)) begin
            err_s = 1'b1;
          end else begin
            emit_s = 1'b1;
          end
        end
        ST_E0: begin
          state_d = ST_IDLE;
          if (data_in == 8'hF0) begin
            state_d = ST_E0F0;
          end else if (is_fake_shift(data_in)) begin
            state_d = ST_IDLE;
          end else if (is_prefix(data_in)) begin
            err_s = 1'b1;
          end else begin
            emit_s     = 1'b1;
            emit_ext_s = 1'b1;
          end
        end
        ST_F0: begin
          state_d = ST_IDLE;
          if (is_prefix(data_in)) begin
            err_s = 1'b1;
          end else begin
            emit_s     = 1'b1;
            emit_brk_s = 1'b1;
          end
        end
        ST_E0F0: begin
          state_d = ST_IDLE;
          if (is_prefix(data_in)) begin
            err_s = 1'b1;
          end else if (is_fake_shift(data_in)) begin
            state_d = ST_IDLE;
          end else begin
            emit_s     = 1'b1;
            emit_ext_s = 1'b1;
            emit_brk_s = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (skip_q <= SKIP_W'(1)) begin
            state_d = ST_IDLE;
            skip_d  = '0;
          end else begin
            skip_d = skip_q - SKIP_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          skip_d  = '0;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (cnt_q >= CNT_MAX) begin
        err_s   = 1'b1;
        state_d = ST_IDLE;
        skip_d  = '0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

`ifdef SCAN_FILTER_REPEAT_SUPPRESS_EN
  logic       store_vld_q;
  logic [8:0] store_key_q;
  logic       store_hit_s;

  // Match of the current event against the last held make (ext bit + code).
  always_comb begin
    store_hit_s = store_vld_q && (store_key_q == {emit_ext_s, data_in});
    suppress_s  = emit_s && !emit_brk_s && store_hit_s;
  end

  // Last-make store: a make replaces it, the matching break releases it.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_vld_q <= 1'b0;
      store_key_q <= 9'h000;
    end else if (emit_s && emit_brk_s) begin
      if (store_hit_s) begin
        store_vld_q <= 1'b0;
      end else begin
        store_vld_q <= store_vld_q;
      end
    end else if (emit_s) begin
      store_vld_q <= 1'b1;
      store_key_q <= {emit_ext_s, data_in};
    end else begin
      store_vld_q <= store_vld_q;
    end
  end
`else
  assign suppress_s = 1'b0;
`endif

  assign fire_s = emit_s && !suppress_s && (REPORT_BREAKS || !emit_brk_s);

  // FSM state, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      skip_q      <= '0;
      ready_q     <= 1'b0;
      key_valid_q <= 1'b0;
      proto_err_q <= 1'b0;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      skip_q      <= skip_d;
      ready_q     <= ready;
      key_valid_q <= fire_s;
      proto_err_q <= err_s;
      if (fire_s) begin
        key_code_q  <= data_in;
        key_ext_q   <= emit_ext_s;
        key_break_q <= emit_brk_s;
      end
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_break = key_break_q;
  assign proto_err = proto_err_q;

endmodule
